// File: rtl/apu_env_pkg.sv
// Shared definitions for the multi-channel volume envelope generator.
// Holds the register-field widths, the packed NRx2-style register layout
// {init_vol, increase, period} and small helpers for field decode and the
// one-step volume arithmetic used by every channel.
package apu_env_pkg;

    localparam int VOL_W    = 4;
    localparam int PERIOD_W = 3;
    localparam int REG_W    = VOL_W + 1 + PERIOD_W;

    typedef struct packed {
        logic [VOL_W-1:0]    init_vol;
        logic                increase;
        logic [PERIOD_W-1:0] period;
    } env_reg_t;

    // The DAC is off only when the register asks for a silent, decreasing envelope.
    function automatic logic env_dac_on(input env_reg_t r);
        return ({r.init_vol, r.increase} != {(VOL_W+1){1'b0}});
    endfunction

    // Period 0 freezes the envelope, so a trigger leaves it inactive.
    function automatic logic env_will_run(input env_reg_t r);
        return (r.period != {PERIOD_W{1'b0}});
    endfunction

    // One volume step computed one bit wider than the volume; the MSB is the
    // carry (past max) or borrow (below 0) and doubles as the clamp flag.
    function automatic logic [VOL_W:0] env_step(input logic [VOL_W-1:0] vol,
                                                 input logic            inc);
        logic [VOL_W:0] wide;
        wide = {1'b0, vol};
        if (inc) begin
            return wide + (VOL_W+1)'(1);
        end else begin
            return wide - (VOL_W+1)'(1);
        end
    endfunction

endpackage

// File: rtl/envelope_gen_mc_env_channel.sv
// One envelope channel.
// Ports:
//   clock, reset_n       single clock, synchronous active-low reset
//   frame_tick           envelope-rate strobe
//   reg_we, reg_wdata    register write strobe and data for this channel
//   trigger              restart strobe
//   volume               current volume (registered)
//   env_active           1 while the envelope is still stepping (registered)
//   dac_en               DAC enable decoded from the register (registered)
// Period and direction are captured at trigger time, so rewriting the
// register mid-envelope only affects the next trigger.
module env_channel
    import apu_env_pkg::*;
(
    input  logic             clock,
    input  logic             reset_n,
    input  logic             frame_tick,
    input  logic             reg_we,
    input  env_reg_t         reg_wdata,
    input  logic             trigger,
    output logic [VOL_W-1:0] volume,
    output logic             env_active,
    output logic             dac_en
);

    env_reg_t            reg_q,    reg_d;
    logic [PERIOD_W-1:0] cnt_q,    cnt_d;
    logic [PERIOD_W-1:0] per_q,    per_d;
    logic                inc_q,    inc_d;
    logic [VOL_W-1:0]    vol_q,    vol_d;
    logic                active_q, active_d;
    logic                dac_en_q, dac_en_d;

    env_reg_t            eff_reg_s;
    logic [VOL_W:0]      step_s;

    // Next-state logic: trigger beats tick; a tick only matters while active.
    always_comb begin
        reg_d    = reg_q;
        cnt_d    = cnt_q;
        per_d    = per_q;
        inc_d    = inc_q;
        vol_d    = vol_q;
        active_d = active_q;

        // A write coinciding with a trigger is seen by the trigger.
        eff_reg_s = reg_we ? reg_wdata : reg_q;
        reg_d     = eff_reg_s;
        dac_en_d  = env_dac_on(reg_d);
        step_s    = env_step(vol_q, inc_q);

        if (trigger) begin
            vol_d    = eff_reg_s.init_vol;
            cnt_d    = eff_reg_s.period;
            per_d    = eff_reg_s.period;
            inc_d    = eff_reg_s.increase;
            active_d = env_will_run(eff_reg_s);
        end else if (frame_tick && active_q) begin
            if (cnt_q == PERIOD_W'(1)) begin
                cnt_d = per_q;
                if (step_s[VOL_W]) begin
                    // Step would leave the range: hold volume, stop until retrigger.
                    active_d = 1'b0;
                end else begin
                    vol_d = step_s[VOL_W-1:0];
                end
            end else begin
                cnt_d = cnt_q - PERIOD_W'(1);
            end
        end else begin
            active_d = active_q;
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            reg_q    <= '0;
            cnt_q    <= '0;
            per_q    <= '0;
            inc_q    <= 1'b0;
            vol_q    <= '0;
            active_q <= 1'b0;
            dac_en_q <= 1'b0;
        end else begin
            reg_q    <= reg_d;
            cnt_q    <= cnt_d;
            per_q    <= per_d;
            inc_q    <= inc_d;
            vol_q    <= vol_d;
            active_q <= active_d;
            dac_en_q <= dac_en_d;
        end
    end

    assign volume     = vol_q;
    assign env_active = active_q;
    assign dac_en     = dac_en_q;

endmodule

// File: rtl/envelope_gen_mc.sv
// Multi-channel volume envelope generator.
// Ports:
//   clock, reset_n   single clock, synchronous active-low reset
//   frame_tick       envelope-rate strobe shared by all channels
//   reg_we[NUM_CH]   per-channel register write strobes
//   reg_wdata        shared write data {init_vol, increase, period}
//   trigger[NUM_CH]  per-channel restart strobes
//   volume           packed volumes, ch0 in the LSBs (registered)
//   env_active       per-channel stepping flag (registered)
//   dac_en           per-channel DAC enable (registered)
module envelope_gen_mc
    import apu_env_pkg::*;
#(
    parameter int NUM_CH = 4
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    frame_tick,
    input  logic [NUM_CH-1:0]       reg_we,
    input  logic [REG_W-1:0]        reg_wdata,
    input  logic [NUM_CH-1:0]       trigger,
    output logic [NUM_CH*VOL_W-1:0] volume,
    output logic [NUM_CH-1:0]       env_active,
    output logic [NUM_CH-1:0]       dac_en
);

    env_reg_t wdata_s;
    assign wdata_s = env_reg_t'(reg_wdata);

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        env_channel u_ch (
            .clock      (clock),
            .reset_n    (reset_n),
            .frame_tick (frame_tick),
            .reg_we     (reg_we[ch]),
            .reg_wdata  (wdata_s),
            .trigger    (trigger[ch]),
            .volume     (volume[ch*VOL_W +: VOL_W]),
            .env_active (env_active[ch]),
            .dac_en     (dac_en[ch])
        );
    end

endmodule
